// File: rtl/key_sequencer_if.sv
// key_sequencer_if: key, command and result channels of the key sequencer plus
// its display/error outputs, grouped so the sequencer takes a single bus port.
// Modports: slave = sequencer side (takes keys, issues commands, takes results);
//           master = environment side (keypad scanner + ALU + display).
interface key_sequencer_if #(
  parameter int WIDTH = 16
);
  logic [4:0]       i_key;
  logic             i_key_valid;
  logic             o_key_ready;
  logic [WIDTH-1:0] o_op_a;
  logic [WIDTH-1:0] o_op_b;
  logic [2:0]       o_opcode;
  logic             o_cmd_valid;
  logic             i_cmd_ready;
  logic [WIDTH-1:0] i_result;
  logic             i_result_err;
  logic             i_result_valid;
  logic             o_result_ready;
  logic [WIDTH-1:0] o_display;
  logic             o_error;

  modport slave (
    input  i_key, i_key_valid, i_cmd_ready, i_result, i_result_err, i_result_valid,
    output o_key_ready, o_op_a, o_op_b, o_opcode, o_cmd_valid, o_result_ready,
    output o_display, o_error
  );

  modport master (
    output i_key, i_key_valid, i_cmd_ready, i_result, i_result_err, i_result_valid,
    input  o_key_ready, o_op_a, o_op_b, o_opcode, o_cmd_valid, o_result_ready,
    input  o_display, o_error
  );
endinterface

// File: rtl/key_sequencer.sv
// Purpose: keypad-to-ALU sequencer; assembles hex operands from key codes, issues
//          {A, B, opcode} commands, takes results, drives display and sticky error.
// Latency: key accept -> o_cmd_valid 1 cycle; o_display registered, 1 cycle after accept.
// Backpressure: o_key_ready low while a command is outstanding (ISSUE/WAIT_RES), so a
//          pending key waits; command operands held stable until i_cmd_ready.
// Ports: clk, rst_n (async, active-low); bus (key_sequencer_if.slave) carries the key
//        channel, command channel, result channel, o_display and o_error.
// Option: define KEY_SEQUENCER_BACKSPACE_EN to make key 10_110 a backspace.
module key_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  key_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    S_ENTER_A, S_OP_PEND, S_ENTER_B, S_ISSUE, S_WAIT_RES, S_SHOW
  } state_e;

  localparam logic [4:0] KEY_AC = 5'b10000;
  localparam logic [4:0] KEY_EQ = 5'b10101;
  localparam logic [4:0] KEY_BS = 5'b10110;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] display_q, display_d;
  logic [2:0]       opcode_q, opcode_d;
  logic [2:0]       next_op_q, next_op_d;
  logic             chain_q, chain_d;
  logic             error_q, error_d;

  logic             key_rdy, cmd_vld, res_rdy;
  logic             key_fire, res_fire, is_digit, is_op, acc_full;
  logic [WIDTH-1:0] digit_ext;

  assign key_fire  = bus.i_key_valid & key_rdy;
  assign res_fire  = bus.i_result_valid & res_rdy;
  assign is_digit  = ~bus.i_key[4];
  // Operators are 10_001..10_100; the low three bits are the opcode itself.
  assign is_op     = (bus.i_key[4:3] == 2'b10) && (bus.i_key[2:0] >= 3'd1) &&
                     (bus.i_key[2:0] <= 3'd4);
  // A non-zero top nibble means all WIDTH/4 digit positions are used.
  assign acc_full  = |acc_q[WIDTH-1:WIDTH-4];
  assign digit_ext = {{(WIDTH-4){1'b0}}, bus.i_key[3:0]};

  // State register (datapath registers share the same reset).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ENTER_A;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      result_q  <= '0;
      display_q <= '0;
      opcode_q  <= 3'd0;
      next_op_q <= 3'd0;
      chain_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      result_q  <= result_d;
      display_q <= display_d;
      opcode_q  <= opcode_d;
      next_op_q <= next_op_d;
      chain_q   <= chain_d;
      error_q   <= error_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    result_d  = result_q;
    opcode_d  = opcode_q;
    next_op_d = next_op_q;
    chain_d   = chain_q;
    error_d   = error_q;

    if (key_fire) begin
      if (bus.i_key == KEY_AC) begin
        state_d = S_ENTER_A;
        acc_d   = '0;
        a_d     = '0;
        b_d     = '0;
        chain_d = 1'b0;
        error_d = 1'b0;
      end else if (is_digit) begin
        case (state_q)
          // Saturation only guards shifting; a fresh operand always starts from d.
          S_ENTER_A, S_ENTER_B: if (!acc_full) acc_d = {acc_q[WIDTH-5:0], bus.i_key[3:0]};
          S_OP_PEND: begin
            acc_d   = digit_ext;
            state_d = S_ENTER_B;
          end
          S_SHOW: begin
            acc_d   = digit_ext;
            error_d = 1'b0;
            state_d = S_ENTER_A;
          end
          default: ;
        endcase
      end else if (is_op) begin
        case (state_q)
          S_ENTER_A: begin
            a_d      = acc_q;
            opcode_d = bus.i_key[2:0];
            state_d  = S_OP_PEND;
          end
          S_OP_PEND: opcode_d = bus.i_key[2:0];
          // Operator after B: run the pending op now, queue this one for the result.
          S_ENTER_B: begin
            b_d       = acc_q;
            next_op_d = bus.i_key[2:0];
            chain_d   = 1'b1;
            state_d   = S_ISSUE;
          end
          S_SHOW: begin
            a_d      = result_q;
            opcode_d = bus.i_key[2:0];
            state_d  = S_OP_PEND;
          end
          default: ;
        endcase
      end else if (bus.i_key == KEY_EQ) begin
        if (state_q == S_ENTER_B) begin
          b_d     = acc_q;
          chain_d = 1'b0;
          state_d = S_ISSUE;
        end
      end
`ifdef KEY_SEQUENCER_BACKSPACE_EN
      else if (bus.i_key == KEY_BS) begin
        case (state_q)
          S_ENTER_A, S_ENTER_B: acc_d = acc_q >> 4;
          // Backing out of a pending operator reopens operand A for editing.
          S_OP_PEND: begin
            acc_d   = a_q;
            state_d = S_ENTER_A;
          end
          default: ;
        endcase
      end
`else
      // 10_110 is an ordinary reserved code here: consumed, no effect.
`endif
    end

    if ((state_q == S_ISSUE) && bus.i_cmd_ready) begin
      state_d = S_WAIT_RES;
    end

    if (res_fire) begin
      result_d = bus.i_result;
      error_d  = bus.i_result_err;
      if (chain_q && !bus.i_result_err) begin
        a_d      = bus.i_result;
        opcode_d = next_op_q;
        chain_d  = 1'b0;
        state_d  = S_OP_PEND;
      end else begin
        state_d = S_SHOW;
      end
    end

    // Display follows the state being entered, so it lands one cycle after the edge.
    case (state_d)
      S_ENTER_A, S_ENTER_B: display_d = acc_d;
      S_SHOW:               display_d = result_d;
      default:              display_d = a_d;
    endcase
  end

  // Output decode.
  always_comb begin
    key_rdy = 1'b0;
    cmd_vld = 1'b0;
    res_rdy = 1'b0;
    case (state_q)
      S_ENTER_A, S_OP_PEND, S_ENTER_B, S_SHOW: key_rdy = 1'b1;
      S_ISSUE:    cmd_vld = 1'b1;
      S_WAIT_RES: res_rdy = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_key_ready    = key_rdy;
  assign bus.o_cmd_valid    = cmd_vld;
  assign bus.o_result_ready = res_rdy;
  assign bus.o_op_a         = a_q;
  assign bus.o_op_b         = b_q;
  assign bus.o_opcode       = opcode_q;
  assign bus.o_display      = display_q;
  assign bus.o_error        = error_q;

endmodule
